// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetch predictions, retired against execute
// outcomes, producing PHT counter updates and a one-cycle flush/redirect on mispredict.
module branch_resolve_unit #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic             pred_taken,
    input  logic [1:0]       pred_ctr,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_idx,
    output logic [1:0]       upd_ctr,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [15:0]      mispredict_cnt,
    output logic             err_underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [1:0]      ctr;
    } entry_t;

    state_t           state;
    entry_t           q [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    entry_t           head_e;
    logic             push, pop, mispred;

    // Counter encoding runs ST=00 .. SNT=11, so taken decrements and not-taken increments.
    function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b00) ? 2'b00 : c - 2'b01;
        else   return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    assign pred_ready = reset && state == RUN && count != FULL;
    assign head_e     = q[head];
    assign pop        = res_valid && count != '0 && state == RUN;
    assign mispred    = pop && (res_taken != head_e.taken);
    // A mispredict squashes any same-cycle push as wrong-path.
    assign push       = pred_valid && pred_ready && !mispred;

    always_ff @(posedge clk) begin
        if (push) q[tail] <= '{pc: pred_pc, taken: pred_taken, ctr: pred_ctr};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= RUN;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            upd_valid      <= 1'b0;
            upd_idx        <= '0;
            upd_ctr        <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            err_underflow  <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            flush     <= 1'b0;
            if (state == FLUSH) state <= RUN;

            if (pop) begin
                upd_valid <= 1'b1;
                upd_idx   <= head_e.pc[IDX_W+1:2];
                upd_ctr   <= next_ctr(head_e.ctr, res_taken);
            end

            if (mispred) begin
                flush       <= 1'b1;
                redirect_pc <= res_taken ? res_target : head_e.pc + PC_W'(4);
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                state       <= FLUSH;
                if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                if (push && !pop)      count <= count + (PTR_W+1)'(1);
                else if (pop && !push) count <= count - (PTR_W+1)'(1);
            end

            if (res_valid && state == RUN && count == '0) err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors checked with immediate assertions.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [1:0]  pred_ctr;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic [1:0]  upd_ctr;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;
    logic        err_underflow;

    int total = 0;
    int bad   = 0;

    branch_resolve_unit #(.PC_W(32), .DEPTH(4), .IDX_W(6)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_ctr(pred_ctr), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ctr(upd_ctr),
        .flush(flush), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] pc, input logic t, input logic [1:0] c);
        pred_valid = 1'b1; pred_pc = pc; pred_taken = t; pred_ctr = c;
        step();
        pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic t, input logic [31:0] tgt);
        res_valid = 1'b1; res_taken = t; res_target = tgt;
        step();
        res_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_ctr = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;

        // reset and idle
        step(); step();
        chk("rst_ready", pred_ready, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_cnt", mispredict_cnt, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_idx", upd_idx, 0);
        chk("rst_ctr", upd_ctr, 0);
        reset = 1'b1;
        step();
        chk("rel_ready", pred_ready, 1);
        chk("rel_upd_valid", upd_valid, 0);

        // correct taken prediction
        push_one(32'h100, 1'b1, 2'b01);
        resolve(1'b1, 32'h0);
        chk("t1_upd_valid", upd_valid, 1);
        chk("t1_idx", upd_idx, 6'h00);
        chk("t1_ctr", upd_ctr, 2'b00);
        chk("t1_flush", flush, 0);
        step();
        chk("t1_strobe_drop", upd_valid, 0);
        chk("t1_ctr_hold", upd_ctr, 2'b00);

        // mispredict: predicted not-taken, resolved taken
        push_one(32'h104, 1'b0, 2'b10);
        resolve(1'b1, 32'h200);
        chk("t2_flush", flush, 1);
        chk("t2_redirect", redirect_pc, 32'h200);
        chk("t2_idx", upd_idx, 6'h01);
        chk("t2_ctr", upd_ctr, 2'b01);
        chk("t2_cnt", mispredict_cnt, 1);
        chk("t2_ready_flush", pred_ready, 0);
        // res_valid during FLUSH is ignored
        resolve(1'b1, 32'h0);
        chk("t2_flush_one", flush, 0);
        chk("t2_ignored_upd", upd_valid, 0);
        chk("t2_ignored_err", err_underflow, 0);
        chk("t2_ready_back", pred_ready, 1);

        // saturation cases
        push_one(32'h10C, 1'b0, 2'b11);
        resolve(1'b0, 32'h0);
        chk("t3_snt_ctr", upd_ctr, 2'b11);
        chk("t3_snt_idx", upd_idx, 6'h03);
        chk("t3_snt_flush", flush, 0);
        push_one(32'h110, 1'b1, 2'b00);
        resolve(1'b1, 32'h0);
        chk("t3_st_ctr", upd_ctr, 2'b00);
        chk("t3_st_idx", upd_idx, 6'h04);
        push_one(32'h3FC, 1'b1, 2'b01);
        resolve(1'b0, 32'h0);
        chk("t3_fall_redirect", redirect_pc, 32'h400);
        chk("t3_fall_ctr", upd_ctr, 2'b10);
        chk("t3_fall_idx", upd_idx, 6'h3F);
        chk("t3_fall_cnt", mispredict_cnt, 2);
        step();

        // fill the queue
        push_one(32'h200, 1'b1, 2'b01);
        push_one(32'h204, 1'b1, 2'b01);
        push_one(32'h208, 1'b1, 2'b01);
        push_one(32'h20C, 1'b1, 2'b01);
        chk("t4_full_ready", pred_ready, 0);
        push_one(32'h210, 1'b1, 2'b01);
        chk("t4_still_full", pred_ready, 0);
        // pop + push while full: pop happens, push rejected
        pred_valid = 1'b1; pred_pc = 32'h214; pred_taken = 1'b1; pred_ctr = 2'b01;
        resolve(1'b1, 32'h0);
        pred_valid = 1'b0;
        chk("t4_pop_upd", upd_valid, 1);
        chk("t4_pop_ctr", upd_ctr, 2'b00);
        chk("t4_count3_ready", pred_ready, 1);
        push_one(32'h218, 1'b1, 2'b01);
        chk("t4_refull", pred_ready, 0);
        // head 0x204 mispredicts with 3 younger entries queued
        resolve(1'b0, 32'h0);
        chk("t4_mp_flush", flush, 1);
        chk("t4_mp_redirect", redirect_pc, 32'h208);
        chk("t4_mp_idx", upd_idx, 6'h01);
        chk("t4_mp_cnt", mispredict_cnt, 3);
        step();
        resolve(1'b1, 32'h0);
        chk("t4_underflow", err_underflow, 1);
        chk("t4_underflow_noupd", upd_valid, 0);

        // reset with two entries in flight
        push_one(32'h300, 1'b1, 2'b01);
        push_one(32'h304, 1'b1, 2'b01);
        reset = 1'b0;
        resolve(1'b0, 32'h0);
        chk("t5_rst_upd", upd_valid, 0);
        chk("t5_rst_flush", flush, 0);
        chk("t5_rst_err", err_underflow, 0);
        chk("t5_rst_cnt", mispredict_cnt, 0);
        chk("t5_rst_ready", pred_ready, 0);
        reset = 1'b1;
        step();
        chk("t5_rel_upd", upd_valid, 0);
        chk("t5_rel_flush", flush, 0);
        chk("t5_rel_ready", pred_ready, 1);
        resolve(1'b0, 32'h0);
        chk("t5_underflow", err_underflow, 1);
        chk("t5_no_upd", upd_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
